receptor_serial: RTL and testbench
==================================

# receptor_serial

Serial-to-parallel frame receiver sitting directly downstream of the 4-bit shift register: its serial input is driven by the register's `S_OUT`, and its bit strobe is the same `ENB` that advances the register. It detects a start bit, assembles an `NBITS`-wide word MSB-first, checks the stop bit (and optionally parity), and presents the word through a one-entry valid/ready output buffer with overrun detection.

## Interface
- `NBITS`, default 4: data bits per frame; legal range 2–16.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `RST`  input  1  reset, asynchronous, active-high.
- `ENB`  input  1  bit strobe; `S_IN` is sampled only on edges where `ENB=1`.
- `S_IN`  input  1  serial line, driven from the shift register's `S_OUT`; idle level 1.
- `RDY`  input  1  consumer ready.
- `DATA`  output  NBITS  received word, valid while `VALID=1`.
- `VALID`  output  1  output buffer holds an unconsumed word.
- `PAR_ERR`  output  1  parity status of the word in `DATA` (only with `PARITY_EN`; otherwise tied 0).
- `FRAME_ERR`  output  1  one-cycle pulse: stop bit sampled as 0.
- `OVERRUN`  output  1  one-cycle pulse: completed word dropped because the buffer was full.

## Operation
- Frame format: start bit 0, `NBITS` data bits MSB first, optional parity bit, stop bit 1.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on edges with `ENB=1`; with `ENB=0` the FSM, counter and shift register hold.
- IDLE: sampled `S_IN=0` → DATA, bit counter cleared. Sampled 1 → stay in IDLE.
- DATA: sampled bit shifted in at LSB (`sh <= {sh[NBITS-2:0], S_IN}`), counter +1. After the `NBITS`-th bit → PARITY if `PARITY_EN`, else STOP.
- PARITY: sample the parity bit → STOP.
- STOP, sampled 1: word complete; deliver per buffer rules below; → IDLE.
- STOP, sampled 0: `FRAME_ERR=1` for one cycle, word discarded, buffer untouched, → IDLE (no break/resync handling; the next 0 sampled in IDLE starts a new frame).
- Output buffer, evaluated on each edge:
  - `VALID & RDY` → word consumed.
  - Completion with buffer empty or consumed in the same edge → `DATA`/`PAR_ERR` loaded, `VALID=1` (back-to-back transfer keeps `VALID` high).
  - Completion with `VALID=1` and `RDY=0` → new word dropped, `DATA` unchanged, `OVERRUN=1` for one cycle.
  - No completion and no consumption → `DATA`, `VALID` and `PAR_ERR` hold. `DATA` is stable while `VALID=1`.
- `RST` asserted: state IDLE, counter 0, shift register 0, `DATA=0`, `VALID=0`, `PAR_ERR=0`, `FRAME_ERR=0`, `OVERRUN=0`. Reset mid-frame discards the partial frame.

## Timing
- All outputs are registered.
- `VALID` goes high after the edge that samples a good stop bit. With `ENB` held 1, that is edge 2+`NBITS` of the frame (edge 3+`NBITS` with parity), counting the start-bit sample as edge 1.
- `FRAME_ERR` and `OVERRUN` are high for exactly one `clk` cycle following the offending edge.
- Throughput: one frame per `NBITS`+2 (+1 with parity) `ENB` strobes. A word is never lost if `RDY` is asserted within one full frame time of `VALID` rising.

## Configuration
- `RECEPTOR_PARITY_EN` defined: the PARITY state is present and even parity is checked. `PAR_ERR` is 1 if XOR(data bits, parity bit) = 1. `PAR_ERR` is registered with the word and held with it; a parity error does not block delivery.
- `RECEPTOR_PARITY_EN` undefined: no PARITY state; frame is `NBITS`+2 bits; `PAR_ERR` is constant 0.

## Test plan
- Reset, then `ENB=1`, no parity, `S_IN` = 0,1,0,1,1,1, `RDY=0` → after edge 6: `DATA=4'b1011`, `VALID=1`; `VALID` holds until `RDY=1`, then drops on that edge.
- With `RECEPTOR_PARITY_EN`, `S_IN` = 0,1,0,1,1,1,1 → `DATA=1011`, `PAR_ERR=0`. Parity bit changed to 0 → `PAR_ERR=1`, `VALID=1`.
- Stop bit 0, `S_IN` = 0,1,1,1,1,0 → `FRAME_ERR` pulses one cycle, `VALID` stays 0.
- Two frames `1011` then `0110` with `RDY=0` throughout → `DATA` stays `1011`, `OVERRUN` pulses once at the second stop bit. Repeat with `RDY=1` on that edge → `DATA=0110`, no `OVERRUN`.
- `ENB` toggling 1,0 each cycle during frame `1011` → same result, completion delayed to edge 11; FSM holds on `ENB=0` edges.
- `RST` pulsed after 3 data bits, then a full frame `0100` → only `0100` delivered; all outputs 0 immediately on `RST` assertion.

Source files
------------

// File: rtl/receptor_serial_if.sv
// Bundle of the bit-strobe/serial line inputs and the valid/ready word output for receptor_serial.
// master drives the line and ready; slave is the receiver.
interface receptor_serial_if #(
  parameter int unsigned NBITS = 4
);
  logic             ENB;
  logic             S_IN;
  logic             RDY;
  logic [NBITS-1:0] DATA;
  logic             VALID;
  logic             PAR_ERR;
  logic             FRAME_ERR;
  logic             OVERRUN;

  modport master (
    output ENB, S_IN, RDY,
    input  DATA, VALID, PAR_ERR, FRAME_ERR, OVERRUN
  );

  modport slave (
    input  ENB, S_IN, RDY,
    output DATA, VALID, PAR_ERR, FRAME_ERR, OVERRUN
  );
endinterface

// File: rtl/receptor_serial.sv
// Serial frame receiver: start bit, NBITS data MSB first, optional even parity, stop bit,
// one-entry valid/ready output buffer. Parity checking enabled by defining RECEPTOR_PARITY_EN.
module receptor_serial #(
  parameter int unsigned NBITS = 4
) (
  input logic             clk,
  input logic             RST,
  receptor_serial_if.slave bus
);
  localparam int unsigned CW = $clog2(NBITS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
`ifdef RECEPTOR_PARITY_EN
  logic             pbit_q, pbit_d;
  logic             par_q, par_d;
`endif

  // State and buffer registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef RECEPTOR_PARITY_EN
      pbit_q  <= 1'b0;
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef RECEPTOR_PARITY_EN
      pbit_q  <= pbit_d;
      par_q   <= par_d;
`endif
    end
  end

  // Frame FSM and output buffer update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef RECEPTOR_PARITY_EN
    pbit_d  = pbit_q;
    par_d   = par_q;
`endif

    if (valid_q && bus.RDY) valid_d = 1'b0;

    if (bus.ENB) begin
      case (state_q)
        S_IDLE: begin
          if (!bus.S_IN) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          sh_d  = {sh_q[NBITS-2:0], bus.S_IN};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NBITS - 1)) begin
`ifdef RECEPTOR_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef RECEPTOR_PARITY_EN
        S_PARITY: begin
          pbit_d  = bus.S_IN;
          state_d = S_STOP;
        end
`endif
        S_STOP: begin
          state_d = S_IDLE;
          if (!bus.S_IN) begin
            ferr_d = 1'b1;
          end else if (!valid_q || bus.RDY) begin
            // Buffer free, or being drained on this same edge
            data_d  = sh_q;
            valid_d = 1'b1;
`ifdef RECEPTOR_PARITY_EN
            par_d   = (^sh_q) ^ pbit_q;
`endif
          end else begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.DATA      = data_q;
  assign bus.VALID     = valid_q;
  assign bus.FRAME_ERR = ferr_q;
  assign bus.OVERRUN   = ovr_q;
`ifdef RECEPTOR_PARITY_EN
  assign bus.PAR_ERR   = par_q;
`else
  assign bus.PAR_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_receptor_serial.sv
// Directed bench for receptor_serial: queue-based frame model checked every cycle,
// plus literal expectations from hand-worked frames.
module tb_receptor_serial;
  localparam int unsigned NB = 4;
`ifdef RECEPTOR_PARITY_EN
  localparam int unsigned FLEN = NB + 3;
`else
  localparam int unsigned FLEN = NB + 2;
`endif

  logic clk = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  receptor_serial_if #(.NBITS(NB)) bus ();

  receptor_serial #(.NBITS(NB)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collect sampled bits from the start bit onward, decode once a whole frame is in
  bit             fr[$];
  logic [NB-1:0]  m_data;
  bit             m_valid, m_par, m_ferr, m_ovr;
  bit             was_valid, got, stop_bit, p;
  logic [NB-1:0]  d;

  always @(posedge clk or posedge RST) begin
    if (RST) begin
      fr.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_par   = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      was_valid = m_valid;
      got       = 1'b0;
      m_ferr    = 1'b0;
      m_ovr     = 1'b0;
      if (m_valid && bus.RDY) m_valid = 1'b0;
      if (bus.ENB) begin
        if (fr.size() != 0 || bus.S_IN == 1'b0) fr.push_back(bus.S_IN);
        if (fr.size() == FLEN) begin
          got = 1'b1;
          for (int i = 0; i < NB; i++) d[NB-1-i] = fr[i+1];
`ifdef RECEPTOR_PARITY_EN
          p = (^d) ^ fr[NB+1];
`else
          p = 1'b0;
`endif
          stop_bit = fr[FLEN-1];
          fr.delete();
        end
      end
      if (got) begin
        if (!stop_bit) m_ferr = 1'b1;
        else if (!was_valid || bus.RDY) begin
          m_data  = d;
          m_par   = p;
          m_valid = 1'b1;
        end else m_ovr = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("data",      32'(bus.DATA),      32'(m_data));
    check("valid",     32'(bus.VALID),     32'(m_valid));
    check("par_err",   32'(bus.PAR_ERR),   32'(m_par));
    check("frame_err", 32'(bus.FRAME_ERR), 32'(m_ferr));
    check("overrun",   32'(bus.OVERRUN),   32'(m_ovr));
  end

  // One rising edge with the given inputs; returns at the following falling edge
  task automatic drive(input bit enb, input bit sin, input bit rdy);
    bus.ENB  = enb;
    bus.S_IN = sin;
    bus.RDY  = rdy;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [NB-1:0] dat, input bit pbad, input bit stop,
                            input bit rdy_last, input bit gap);
    bit b[$];
    b.push_back(1'b0);
    for (int i = NB - 1; i >= 0; i--) b.push_back(dat[i]);
`ifdef RECEPTOR_PARITY_EN
    b.push_back((^dat) ^ pbad);
`endif
    for (int i = 0; i < b.size(); i++) begin
      drive(1'b1, b[i], 1'b0);
      if (gap) drive(1'b0, ~b[i], 1'b0);
    end
    drive(1'b1, stop, rdy_last);
  endtask

  initial begin
    RST      = 1'b1;
    bus.ENB  = 1'b0;
    bus.S_IN = 1'b1;
    bus.RDY  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.VALID), 32'd0);
    check("rst_data",  32'(bus.DATA),  32'd0);
    check("rst_ferr",  32'(bus.FRAME_ERR), 32'd0);
    check("rst_ovr",   32'(bus.OVERRUN),   32'd0);
    RST = 1'b0;

    // Basic frame 1011, held until ready
    send_frame(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t1_data",  32'(bus.DATA),    32'hB);
    check("t1_valid", 32'(bus.VALID),   32'd1);
    check("t1_par",   32'(bus.PAR_ERR), 32'd0);
    repeat (3) drive(1'b0, 1'b1, 1'b0);
    check("t1_hold",  32'(bus.VALID),   32'd1);
    drive(1'b0, 1'b1, 1'b1);
    check("t1_drop",  32'(bus.VALID),   32'd0);

`ifdef RECEPTOR_PARITY_EN
    send_frame(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    check("par_bad_flag",  32'(bus.PAR_ERR), 32'd1);
    check("par_bad_valid", 32'(bus.VALID),   32'd1);
    drive(1'b0, 1'b1, 1'b1);
`endif

    // Stop bit sampled 0
    send_frame(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fe_pulse", 32'(bus.FRAME_ERR), 32'd1);
    check("fe_valid", 32'(bus.VALID),     32'd0);
    drive(1'b1, 1'b1, 1'b0);
    check("fe_clear", 32'(bus.FRAME_ERR), 32'd0);

    // Overrun: second word dropped while the first waits
    send_frame(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_pulse", 32'(bus.OVERRUN), 32'd1);
    check("ovr_data",  32'(bus.DATA),    32'hB);
    drive(1'b1, 1'b1, 1'b0);
    check("ovr_clear", 32'(bus.OVERRUN), 32'd0);
    drive(1'b0, 1'b1, 1'b1);
    check("ovr_drain", 32'(bus.VALID),   32'd0);

    // Same pair, consumer ready on the second stop edge
    send_frame(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1, 1'b1, 1'b0);
    check("b2b_data",  32'(bus.DATA),    32'h6);
    check("b2b_valid", 32'(bus.VALID),   32'd1);
    check("b2b_ovr",   32'(bus.OVERRUN), 32'd0);
    drive(1'b0, 1'b1, 1'b1);

    // Strobe every other cycle, line toggled on the idle edges
    send_frame(4'b1011, 1'b0, 1'b1, 1'b0, 1'b1);
    check("gap_data",  32'(bus.DATA),  32'hB);
    check("gap_valid", 32'(bus.VALID), 32'd1);

    // Reset mid-frame with a word still buffered
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    #2 RST = 1'b1;
    #1;
    check("arst_valid", 32'(bus.VALID),     32'd0);
    check("arst_data",  32'(bus.DATA),      32'd0);
    check("arst_ferr",  32'(bus.FRAME_ERR), 32'd0);
    check("arst_ovr",   32'(bus.OVERRUN),   32'd0);
    @(negedge clk);
    RST = 1'b0;
    send_frame(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
    check("post_rst_data",  32'(bus.DATA),  32'h4);
    check("post_rst_valid", 32'(bus.VALID), 32'd1);
    drive(1'b0, 1'b1, 1'b1);
    check("post_rst_drop",  32'(bus.VALID), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
